// File: rtl/multi_stack.sv
// N independent LIFO stacks of D words each, sharing one command port.
// Pops return data one cycle later on dout; top/count peek the selected stack.
module multi_stack #(
    parameter int W = 13,
    parameter int D = 8,
    parameter int N = 2,
    localparam int SW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [SW-1:0] sel,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          dout_valid,
    output logic [W-1:0]  top,
    output logic [CW-1:0] count,
    output logic [N-1:0]  empty,
    output logic [N-1:0]  full,
    output logic          err_ovf,
    output logic          err_udf
);
    localparam int AW = $clog2(D);

    logic          sel_ok;
    logic [CW-1:0] cnt_w [N];
    logic [W-1:0]  top_w [N];
    logic          sel_empty;
    logic          sel_full;

    logic [W-1:0]  dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    // A select value beyond the last stack turns the cycle into a no-op.
    assign sel_ok = (int'(sel) < N);

    for (genvar gi = 0; gi < N; gi++) begin : g_stack
        logic [W-1:0]  mem [D];
        logic [CW-1:0] cnt_q, cnt_d;
        logic          hit, is_empty, is_full, we;
        logic [AW-1:0] waddr, raddr;

        assign hit      = sel_ok && (sel == SW'(gi));
        assign is_empty = (cnt_q == '0);
        assign is_full  = (cnt_q == CW'(D));
        assign raddr    = AW'(cnt_q - 1'b1);

        always_comb begin
            cnt_d = cnt_q;
            we    = 1'b0;
            waddr = AW'(cnt_q);
            if (hit) begin
                if (clear) begin
                    cnt_d = '0;
                end else if (push && pop) begin
                    // Replace the top in place; an empty stack just passes din through.
                    if (!is_empty) begin
                        we    = 1'b1;
                        waddr = raddr;
                    end
                end else if (push) begin
                    if (!is_full) begin
                        we    = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (pop) begin
                    if (!is_empty) cnt_d = cnt_q - 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end

        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= din;
        end

        assign top_w[gi] = is_empty ? '0 : mem[raddr];
        assign cnt_w[gi] = cnt_q;
        assign empty[gi] = is_empty;
        assign full[gi]  = is_full;
    end

    always_comb begin
        top   = '0;
        count = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_ok && (sel == SW'(i))) begin
                top   = top_w[i];
                count = cnt_w[i];
            end
        end
    end

    assign sel_empty = (count == '0);
    assign sel_full  = (count == CW'(D));

    always_comb begin
        dout_d  = dout_q;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (sel_ok && !clear) begin
            if (push && pop) begin
                valid_d = 1'b1;
                dout_d  = sel_empty ? din : top;
            end else if (push) begin
                ovf_d = sel_full;
            end else if (pop) begin
                if (sel_empty) begin
                    udf_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    dout_d  = top;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign err_ovf    = ovf_q;
    assign err_udf    = udf_q;
endmodule

// File: tb/tb_multi_stack.sv
// Directed vector table for multi_stack (W=13, D=8, N=2) plus a reset-mid-push sequence.
module tb_multi_stack;
    localparam int W  = 13;
    localparam int D  = 8;
    localparam int N  = 2;
    localparam int SW = 1;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] sel;
    logic          clear, push, pop;
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic [W-1:0]  top;
    logic [CW-1:0] count;
    logic [N-1:0]  empty, full;
    logic          err_ovf, err_udf;

    int ncmp = 0;
    int nerr = 0;

    multi_stack #(.W(W), .D(D), .N(N)) dut (
        .clk(clk), .reset(reset), .sel(sel), .clear(clear), .push(push), .pop(pop),
        .din(din), .dout(dout), .dout_valid(dout_valid), .top(top), .count(count),
        .empty(empty), .full(full), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] sel;
        logic          clr, psh, pp;
        logic [W-1:0]  din;
        logic [W-1:0]  e_dout;
        logic          e_dv;
        logic [W-1:0]  e_top;
        logic [CW-1:0] e_cnt;
        logic [N-1:0]  e_empty, e_full;
        logic          e_ovf, e_udf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int s, input int c, input int pu, input int po, input int d,
                       input int edout, input int edv, input int etop, input int ecnt,
                       input int eempty, input int efull, input int eovf, input int eudf);
        vec_t v;
        v.sel = SW'(s); v.clr = 1'(c); v.psh = 1'(pu); v.pp = 1'(po); v.din = W'(d);
        v.e_dout = W'(edout); v.e_dv = 1'(edv); v.e_top = W'(etop); v.e_cnt = CW'(ecnt);
        v.e_empty = N'(eempty); v.e_full = N'(efull); v.e_ovf = 1'(eovf); v.e_udf = 1'(eudf);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " dout"},  32'(dout),       32'(v.e_dout));
        check({tag, " dv"},    32'(dout_valid), 32'(v.e_dv));
        check({tag, " top"},   32'(top),        32'(v.e_top));
        check({tag, " count"}, 32'(count),      32'(v.e_cnt));
        check({tag, " empty"}, 32'(empty),      32'(v.e_empty));
        check({tag, " full"},  32'(full),       32'(v.e_full));
        check({tag, " ovf"},   32'(err_ovf),    32'(v.e_ovf));
        check({tag, " udf"},   32'(err_udf),    32'(v.e_udf));
    endtask

    task automatic drive(input int s, input int c, input int pu, input int po, input int d);
        sel = SW'(s); clear = 1'(c); push = 1'(pu); pop = 1'(po); din = W'(d);
    endtask

    initial begin
        vec_t rv;
        // LIFO order on stack 0, then underflow
        add(0,0,1,0,'h001, 'h000,0,'h001,1, 'b10,'b00,0,0);
        add(0,0,1,0,'h002, 'h000,0,'h002,2, 'b10,'b00,0,0);
        add(0,0,1,0,'h003, 'h000,0,'h003,3, 'b10,'b00,0,0);
        add(0,0,0,1,'h000, 'h003,1,'h002,2, 'b10,'b00,0,0);
        add(0,0,0,1,'h000, 'h002,1,'h001,1, 'b10,'b00,0,0);
        add(0,0,0,1,'h000, 'h001,1,'h000,0, 'b11,'b00,0,0);
        add(0,0,0,1,'h000, 'h001,0,'h000,0, 'b11,'b00,0,1);
        // fill stack 1, then overflow
        for (int k = 0; k < D; k++)
            add(1,0,1,0,'h100+k, 'h001,0,'h100+k,k+1, 'b01,(k == D-1) ? 'b10 : 'b00,0,0);
        add(1,0,1,0,'h108, 'h001,0,'h107,8, 'b01,'b10,1,0);
        add(0,0,0,0,'h000, 'h001,0,'h000,0, 'b01,'b10,0,0);
        // push+pop on non-empty and empty stack 0
        add(0,0,1,0,'h0AA, 'h001,0,'h0AA,1, 'b00,'b10,0,0);
        add(0,0,1,1,'h155, 'h0AA,1,'h155,1, 'b00,'b10,0,0);
        add(0,0,0,1,'h000, 'h155,1,'h000,0, 'b01,'b10,0,0);
        add(0,0,1,1,'h1FF, 'h1FF,1,'h000,0, 'b01,'b10,0,0);
        // push+pop on full stack 1, drain to 3 words, then clear beats push
        add(1,0,1,1,'h0F0, 'h107,1,'h0F0,8, 'b01,'b10,0,0);
        add(1,0,0,1,'h000, 'h0F0,1,'h106,7, 'b01,'b00,0,0);
        add(1,0,0,1,'h000, 'h106,1,'h105,6, 'b01,'b00,0,0);
        add(1,0,0,1,'h000, 'h105,1,'h104,5, 'b01,'b00,0,0);
        add(1,0,0,1,'h000, 'h104,1,'h103,4, 'b01,'b00,0,0);
        add(1,0,0,1,'h000, 'h103,1,'h102,3, 'b01,'b00,0,0);
        add(1,1,1,0,'h0EE, 'h103,0,'h000,0, 'b11,'b00,0,0);
        add(1,0,1,0,'h011, 'h103,0,'h011,1, 'b01,'b00,0,0);

        drive(0,0,0,0,0);
        reset = 1'b1;
        #2;
        rv = '{sel:0, clr:0, psh:0, pp:0, din:0, e_dout:0, e_dv:0, e_top:0, e_cnt:0,
               e_empty:2'b11, e_full:2'b00, e_ovf:0, e_udf:0};
        check_all("reset", rv);
        $display("reset: empty=%b full=%b dout=0x%0h", empty, full, dout);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(int'(vecs[i].sel), int'(vecs[i].clr), int'(vecs[i].psh), int'(vecs[i].pp),
                  int'(vecs[i].din));
            @(posedge clk);
            #1;
            $display("vec %0d: sel=%0d clr=%0d push=%0d pop=%0d din=0x%0h -> dout=0x%0h dv=%0d top=0x%0h cnt=%0d",
                     i, sel, clear, push, pop, din, dout, dout_valid, top, count);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // reset asserted asynchronously while a push is pending on stack 1
        @(negedge clk);
        drive(1,0,1,0,'h022);
        #2;
        reset = 1'b1;
        #1;
        rv = '{sel:1, clr:0, psh:1, pp:0, din:'h022, e_dout:0, e_dv:0, e_top:0, e_cnt:0,
               e_empty:2'b11, e_full:2'b00, e_ovf:0, e_udf:0};
        check_all("midreset", rv);
        $display("midreset: empty=%b dout=0x%0h cnt=%0d", empty, dout, count);
        @(posedge clk);
        #1;
        check_all("heldreset", rv);
        @(negedge clk);
        reset = 1'b0;
        drive(1,0,0,1,0);
        @(posedge clk);
        #1;
        rv = '{sel:1, clr:0, psh:0, pp:1, din:0, e_dout:0, e_dv:0, e_top:0, e_cnt:0,
               e_empty:2'b11, e_full:2'b00, e_ovf:0, e_udf:1};
        check_all("postreset", rv);
        $display("postreset pop: udf=%0d dv=%0d cnt=%0d", err_udf, dout_valid, count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
